// File: rtl/core_pkg.sv
// ============================================================================
// Module  : core_pkg
// Brief   : Shared fetch-side types and constants for the pipelined core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam int unsigned PC_INC = 4;

    // Shared with the instruction memory so both agree on the boot address.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : core_pkg

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module  : pc_reg
// Brief   : Program counter register with synchronous active-low reset and enable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_reg #(
    parameter int unsigned         DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : pc_reg

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module  : fetch_ctrl
// Brief   : Program counter, fetch/decode stage control and fetch event counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
    import core_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallF_i,
    input  logic                  PCSrcE_i,
    input  logic [DATA_WIDTH-1:0] PCTargetE_i,
    output logic [DATA_WIDTH-1:0] PCF_o,
    output logic [DATA_WIDTH-1:0] PCPlus4F_o,
    output logic                  Fen_o,
    output logic                  Frst_o,
    output logic                  FlushE_o,
    output logic                  MisalignErr_o,
    output logic [DATA_WIDTH-1:0] FetchCount_o,
    output logic [DATA_WIDTH-1:0] RedirectCount_o
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic                  pc_en;
    logic [DATA_WIDTH-1:0] pc_next;
    logic                  redirect;
    logic                  advance;

    pc_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_VAL  (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_en),
        .d     (pc_next),
        .q     (PCF_o)
    );

    assign PCPlus4F_o = PCF_o + DATA_WIDTH'(PC_INC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        redirect   = 1'b0;
        advance    = 1'b0;
        pc_en      = 1'b0;
        pc_next    = PCPlus4F_o;
        Frst_o     = 1'b1;
        Fen_o      = 1'b1;
        FlushE_o   = 1'b0;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                redirect = PCSrcE_i;
                advance  = ~PCSrcE_i & ~StallF_i;
                pc_en    = redirect | advance;
                if (redirect) begin
                    pc_next = {PCTargetE_i[DATA_WIDTH-1:2], 2'b00};
                end
                // Flush must win over stall, so the enable is forced high on redirect.
                Frst_o   = PCSrcE_i;
                Fen_o    = ~StallF_i | PCSrcE_i;
                FlushE_o = PCSrcE_i | StallF_i;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            FetchCount_o    <= '0;
            RedirectCount_o <= '0;
            MisalignErr_o   <= 1'b0;
        end else begin
            if (advance) begin
                FetchCount_o <= FetchCount_o + 1'b1;
            end
            if (redirect) begin
                RedirectCount_o <= RedirectCount_o + 1'b1;
                if (PCTargetE_i[1:0] != 2'b00) begin
                    MisalignErr_o <= 1'b1;
                end
            end
        end
    end

endmodule : fetch_ctrl

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module  : tb_fetch_ctrl
// Brief   : Directed self-checking bench for fetch_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF_i;
    logic        PCSrcE_i;
    logic [31:0] PCTargetE_i;
    logic [31:0] PCF_o;
    logic [31:0] PCPlus4F_o;
    logic        Fen_o;
    logic        Frst_o;
    logic        FlushE_o;
    logic        MisalignErr_o;
    logic [31:0] FetchCount_o;
    logic [31:0] RedirectCount_o;

    int compared   = 0;
    int mismatched = 0;

    fetch_ctrl #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .StallF_i        (StallF_i),
        .PCSrcE_i        (PCSrcE_i),
        .PCTargetE_i     (PCTargetE_i),
        .PCF_o           (PCF_o),
        .PCPlus4F_o      (PCPlus4F_o),
        .Fen_o           (Fen_o),
        .Frst_o          (Frst_o),
        .FlushE_o        (FlushE_o),
        .MisalignErr_o   (MisalignErr_o),
        .FetchCount_o    (FetchCount_o),
        .RedirectCount_o (RedirectCount_o)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change 1ns after the edge, checks 1ns after that.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; StallF_i = 1'b0; PCSrcE_i = 1'b0; PCTargetE_i = 32'h0;
        step(); step(); #1;
        compared++; if (PCF_o !== 32'h0) begin mismatched++; $display("FAIL reset_pc got=%h exp=%h", PCF_o, 32'h0); end
        compared++; if (PCPlus4F_o !== 32'h4) begin mismatched++; $display("FAIL reset_pcplus4 got=%h exp=%h", PCPlus4F_o, 32'h4); end
        compared++; if ({Frst_o, Fen_o, FlushE_o} !== 3'b110) begin mismatched++; $display("FAIL reset_ctrl got=%b exp=110", {Frst_o, Fen_o, FlushE_o}); end
        compared++; if (MisalignErr_o !== 1'b0) begin mismatched++; $display("FAIL reset_misalign got=%b exp=0", MisalignErr_o); end
        compared++; if ({FetchCount_o, RedirectCount_o} !== 64'h0) begin mismatched++; $display("FAIL reset_counts got=%h/%h exp=0/0", FetchCount_o, RedirectCount_o); end
    endtask

    task automatic test_idle();
        logic [31:0] exp_pc [5];
        exp_pc = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
        rst_n = 1'b1; #1;
        // First cycle after reset is BOOT: NOP into decode, PC parked.
        compared++; if (Frst_o !== 1'b1) begin mismatched++; $display("FAIL boot_frst got=%b exp=1", Frst_o); end
        for (int i = 0; i < 5; i++) begin
            compared++; if (PCF_o !== exp_pc[i]) begin mismatched++; $display("FAIL idle_pc[%0d] got=%h exp=%h", i, PCF_o, exp_pc[i]); end
            step(); #1;
        end
        compared++; if (Frst_o !== 1'b0) begin mismatched++; $display("FAIL run_frst got=%b exp=0", Frst_o); end
        compared++; if (PCF_o !== 32'h10) begin mismatched++; $display("FAIL idle_pc_end got=%h exp=%h", PCF_o, 32'h10); end
        compared++; if (FetchCount_o !== 32'd4) begin mismatched++; $display("FAIL idle_fetchcnt got=%0d exp=4", FetchCount_o); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            StallF_i = 1'b1; #1;
            compared++; if (PCF_o !== 32'h10) begin mismatched++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, PCF_o, 32'h10); end
            compared++; if ({Fen_o, FlushE_o, Frst_o} !== 3'b010) begin mismatched++; $display("FAIL stall_ctrl[%0d] got=%b exp=010", i, {Fen_o, FlushE_o, Frst_o}); end
            step();
        end
        StallF_i = 1'b0; #1;
        compared++; if (PCF_o !== 32'h10) begin mismatched++; $display("FAIL stall_held got=%h exp=%h", PCF_o, 32'h10); end
        compared++; if ({Fen_o, FlushE_o} !== 2'b10) begin mismatched++; $display("FAIL stall_release_ctrl got=%b exp=10", {Fen_o, FlushE_o}); end
        step(); #1;
        compared++; if (PCF_o !== 32'h14) begin mismatched++; $display("FAIL stall_resume got=%h exp=%h", PCF_o, 32'h14); end
        compared++; if (FetchCount_o !== 32'd5) begin mismatched++; $display("FAIL stall_fetchcnt got=%0d exp=5", FetchCount_o); end
    endtask

    task automatic test_redirect();
        step(); step(); step(); #1;
        compared++; if (PCF_o !== 32'h20) begin mismatched++; $display("FAIL redir_pre_pc got=%h exp=%h", PCF_o, 32'h20); end
        PCSrcE_i = 1'b1; PCTargetE_i = 32'h100; #1;
        compared++; if ({Frst_o, FlushE_o, Fen_o} !== 3'b111) begin mismatched++; $display("FAIL redir_ctrl got=%b exp=111", {Frst_o, FlushE_o, Fen_o}); end
        step();
        PCSrcE_i = 1'b0; #1;
        compared++; if (PCF_o !== 32'h100) begin mismatched++; $display("FAIL redir_pc got=%h exp=%h", PCF_o, 32'h100); end
        compared++; if (RedirectCount_o !== 32'd1) begin mismatched++; $display("FAIL redir_cnt got=%0d exp=1", RedirectCount_o); end
        compared++; if (FetchCount_o !== 32'd8) begin mismatched++; $display("FAIL redir_fetchcnt got=%0d exp=8", FetchCount_o); end
    endtask

    task automatic test_simultaneous();
        StallF_i = 1'b1; PCSrcE_i = 1'b1; PCTargetE_i = 32'h40; #1;
        compared++; if ({Fen_o, Frst_o, FlushE_o} !== 3'b111) begin mismatched++; $display("FAIL simul_ctrl got=%b exp=111", {Fen_o, Frst_o, FlushE_o}); end
        step();
        StallF_i = 1'b0; PCSrcE_i = 1'b0; #1;
        compared++; if (PCF_o !== 32'h40) begin mismatched++; $display("FAIL simul_pc got=%h exp=%h", PCF_o, 32'h40); end
        compared++; if (RedirectCount_o !== 32'd2) begin mismatched++; $display("FAIL simul_cnt got=%0d exp=2", RedirectCount_o); end
    endtask

    task automatic test_back_to_back();
        PCSrcE_i = 1'b1; PCTargetE_i = 32'h202;
        step(); #1;
        compared++; if (PCF_o !== 32'h200) begin mismatched++; $display("FAIL misalign_pc got=%h exp=%h", PCF_o, 32'h200); end
        compared++; if (MisalignErr_o !== 1'b1) begin mismatched++; $display("FAIL misalign_flag got=%b exp=1", MisalignErr_o); end
        compared++; if (PCPlus4F_o !== 32'h204) begin mismatched++; $display("FAIL misalign_pcplus4 got=%h exp=%h", PCPlus4F_o, 32'h204); end
        PCTargetE_i = 32'hFFFF_FFFC;
        step(); #1;
        PCSrcE_i = 1'b0; #1;
        compared++; if (PCF_o !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL b2b_pc got=%h exp=%h", PCF_o, 32'hFFFF_FFFC); end
        compared++; if (PCPlus4F_o !== 32'h0) begin mismatched++; $display("FAIL wrap_pcplus4 got=%h exp=%h", PCPlus4F_o, 32'h0); end
        compared++; if (RedirectCount_o !== 32'd4) begin mismatched++; $display("FAIL b2b_cnt got=%0d exp=4", RedirectCount_o); end
        compared++; if (MisalignErr_o !== 1'b1) begin mismatched++; $display("FAIL misalign_sticky got=%b exp=1", MisalignErr_o); end
        step(); #1;
        compared++; if (PCF_o !== 32'h0) begin mismatched++; $display("FAIL wrap_pc got=%h exp=%h", PCF_o, 32'h0); end
        compared++; if (FetchCount_o !== 32'd9) begin mismatched++; $display("FAIL wrap_fetchcnt got=%0d exp=9", FetchCount_o); end
    endtask

    task automatic test_midrun_reset();
        PCSrcE_i = 1'b1; PCTargetE_i = 32'h300;
        step();
        PCSrcE_i = 1'b0; #1;
        compared++; if (PCF_o !== 32'h300) begin mismatched++; $display("FAIL mid_pre_pc got=%h exp=%h", PCF_o, 32'h300); end
        // Reset during a stall with a redirect also pending: reset must dominate.
        StallF_i = 1'b1; PCSrcE_i = 1'b1; PCTargetE_i = 32'h500; rst_n = 1'b0;
        step(); #1;
        compared++; if (PCF_o !== 32'h0) begin mismatched++; $display("FAIL mid_pc got=%h exp=%h", PCF_o, 32'h0); end
        compared++; if ({FetchCount_o, RedirectCount_o} !== 64'h0) begin mismatched++; $display("FAIL mid_counts got=%h/%h exp=0/0", FetchCount_o, RedirectCount_o); end
        compared++; if (MisalignErr_o !== 1'b0) begin mismatched++; $display("FAIL mid_misalign got=%b exp=0", MisalignErr_o); end
        compared++; if ({Frst_o, Fen_o, FlushE_o} !== 3'b110) begin mismatched++; $display("FAIL mid_boot_ctrl got=%b exp=110", {Frst_o, Fen_o, FlushE_o}); end
        rst_n = 1'b1;
        step(); #1;
        // BOOT ignored the pending stall/redirect, so PC is still the reset value.
        compared++; if (PCF_o !== 32'h0) begin mismatched++; $display("FAIL boot_ignore_pc got=%h exp=%h", PCF_o, 32'h0); end
        compared++; if (RedirectCount_o !== 32'd0) begin mismatched++; $display("FAIL boot_ignore_cnt got=%0d exp=0", RedirectCount_o); end
        StallF_i = 1'b0; PCSrcE_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_stall();
        test_redirect();
        test_simultaneous();
        test_back_to_back();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fetch_ctrl

`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-side controller for the pipelined core: owns the program counter, drives PCF/PCPlus4F into the fetch/decode register stage, and generates that stage's enable and flush (Fen/Frst) plus the execute-stage flush. It sits upstream of the instruction memory and the fetch pipeline register. It applies branch/jump redirects from execute and load-use stalls from the hazard logic. It also keeps fetch and redirect event counters for performance bring-up.

## Interface
- DATA_WIDTH, 32, width of PC and counters
- RESET_PC, 32'h0, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- StallF_i  in  1  hold PC and decode register (load-use hazard)
- PCSrcE_i  in  1  taken branch/jump resolved in execute
- PCTargetE_i  in  DATA_WIDTH  redirect target from execute
- PCF_o  out  DATA_WIDTH  current fetch PC (registered)
- PCPlus4F_o  out  DATA_WIDTH  PCF_o + 4
- Fen_o  out  1  enable for fetch/decode register
- Frst_o  out  1  flush (insert NOP) for fetch/decode register
- FlushE_o  out  1  flush for decode/execute register
- MisalignErr_o  out  1  sticky: redirect target had nonzero bits [1:0]
- FetchCount_o  out  DATA_WIDTH  count of cycles the PC advanced sequentially
- RedirectCount_o  out  DATA_WIDTH  count of accepted redirects

## Operation
- FSM, 2 states: BOOT, RUN. Reset → BOOT. BOOT → RUN unconditionally after one cycle. No path back to BOOT except reset.
- BOOT: PC holds RESET_PC. Frst_o=1, Fen_o=1 (decode register gets a NOP). Inputs StallF_i/PCSrcE_i ignored. No counter increments.
- RUN, next-PC priority: PCSrcE_i > StallF_i > sequential.
  - PCSrcE_i=1: PC ← {PCTargetE_i[DW-1:2], 2'b00}. If PCTargetE_i[1:0]≠0, set MisalignErr_o. RedirectCount_o += 1.
  - else StallF_i=1: PC holds.
  - else: PC ← PC+4, FetchCount_o += 1.
- Combinational outputs in RUN:
  - Frst_o = PCSrcE_i.
  - Fen_o = ~StallF_i | PCSrcE_i. Flush must always win, so the enable is forced high when flushing.
  - FlushE_o = PCSrcE_i | StallF_i. A stall inserts an execute bubble.
- Arithmetic: PC+4 and both counters are modulo 2^DATA_WIDTH. 32'hFFFFFFFC+4 = 0. Counters wrap to 0 with no flag.
- MisalignErr_o stays set until reset.

## Timing
- Reset values after an edge with rst_n=0:
  - PCF_o=RESET_PC, PCPlus4F_o=RESET_PC+4
  - state=BOOT, Frst_o=1, Fen_o=1, FlushE_o=0
  - MisalignErr_o=0, both counters 0
- PCF_o changes only on the clock edge. PCPlus4F_o, Fen_o, Frst_o and FlushE_o are combinational from state and inputs, same cycle.
- Redirect latency: PCSrcE_i high in cycle N → PCF_o=target in cycle N+1. Frst_o and FlushE_o are high in cycle N, squashing the two younger instructions.
- Stall: StallF_i high for k cycles → PCF_o constant for those k cycles. Fen_o and FlushE_o track StallF_i cycle-for-cycle.
- Redirect and stall in the same cycle: the redirect is taken and the stall is discarded. Fen_o=1, Frst_o=1.
- Back-to-back redirects: each cycle's PCSrcE_i is honored. RedirectCount_o increments every such cycle.
- rst_n low mid-operation: at the next edge everything returns to the reset values, regardless of stall or redirect inputs.

## Structure
- Shared package core_pkg holds:
  - typedef fetch_state_t {BOOT, RUN}
  - localparam PC_INC = 4
  - the RESET_PC default, so the core top and the instruction memory agree.
- One natural sub-module: pc_reg, the DATA_WIDTH register with sync active-low reset and enable that holds the PC. Counters and FSM are inline.

## Test plan
- Reset then idle (StallF_i=0, PCSrcE_i=0) for 5 cycles → BOOT cycle shows PCF_o=0 with Frst_o=1. Then PCF_o goes 0,4,8,C and FetchCount_o=4.
- Stall: in RUN at PCF_o=0x10, hold StallF_i=1 for 3 cycles → PCF_o stays 0x10, Fen_o=0, FlushE_o=1. After release, PCF_o=0x14 next cycle.
- Redirect: at PCF_o=0x20, assert PCSrcE_i with PCTargetE_i=0x100 → Frst_o=FlushE_o=1 that cycle. Next cycle PCF_o=0x100, RedirectCount_o=1.
- Simultaneous: assert StallF_i=1 and PCSrcE_i=1 with target 0x40 → Fen_o=1, Frst_o=1, next PCF_o=0x40.
- Misaligned and wrap: redirect to 0x202 → PCF_o=0x200 and MisalignErr_o=1 stays set. Redirect to 0xFFFFFFFC, then one free cycle → PCF_o=0.
- Mid-run reset: pull rst_n low during a stall at PCF_o=0x300 → next edge PCF_o=RESET_PC, counters 0, MisalignErr_o=0, BOOT flush visible.
